elevator_car_controller: RTL and testbench

Car-motion stage of the elevator design: latches floor calls, schedules car travel with a direction-preserving sweep (serve all calls ahead, then reverse), times floor-to-floor travel and door dwell, and produces the 1-based `current_floor` and active-low `door_n` strobe. These two outputs feed the downstream door-opening stage, which opens the door of `current_floor` while `door_n` is low.

---
 rtl/elevator_car_controller.sv | 163 ++++++++++++++++
 tb/tb_elevator_car_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_controller.sv
// Elevator car-motion controller: latches floor calls, runs a direction-preserving sweep,
// times floor travel and door dwell. Define ELEVATOR_DOOR_HOLD_EN to add the door_hold_i input.
module elevator_car_controller #(
   parameter int unsigned FLOORS        = 6,
   parameter int unsigned TRAVEL_CYCLES = 50_000_000,
   parameter int unsigned DOOR_CYCLES   = 150_000_000
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic [FLOORS-1:0] call_req_i,
`ifdef ELEVATOR_DOOR_HOLD_EN
   input  logic              door_hold_i,
`endif
   output logic [2:0]        current_floor_o,
   output logic              door_n_o,
   output logic              moving_o,
   output logic              dir_up_o,
   output logic [FLOORS-1:0] pending_o
);

   localparam int unsigned MaxCycles = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES
                                                                      : DOOR_CYCLES;
   localparam int unsigned TimerW    = $clog2(MaxCycles + 1);

   localparam logic [TimerW-1:0] TravelLast = TimerW'(TRAVEL_CYCLES - 1);
   localparam logic [TimerW-1:0] DoorLast   = TimerW'(DOOR_CYCLES - 1);
   localparam logic [TimerW-1:0] TimerOne   = TimerW'(1);
   localparam logic [2:0]        TopFloor   = 3'(FLOORS);

   typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

   state_e              state_q, state_d;
   logic [2:0]          floor_q, floor_d;
   logic                dir_up_q, dir_up_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [FLOORS-1:0]   pending_q, pending_d;

   logic [FLOORS-1:0]   cur_oh, next_oh, above, below;
   logic [FLOORS-1:0]   req_masked, clear;
   logic [2:0]          next_floor, clamp_floor;
   logic                ahead, behind, step_ok, hold;

`ifdef ELEVATOR_DOOR_HOLD_EN
   assign hold = door_hold_i;
`else
   assign hold = 1'b0;
`endif

   // Floor-relative masks; "ahead"/"behind" depend on the current sweep direction.
   always_comb begin : decode
      next_floor = dir_up_q ? (floor_q + 3'd1) : (floor_q - 3'd1);
      cur_oh     = '0;
      next_oh    = '0;
      above      = '0;
      below      = '0;
      for (int unsigned i = 0; i < FLOORS; i++) begin
         cur_oh[i]  = (32'(floor_q) == i + 1);
         next_oh[i] = (32'(next_floor) == i + 1);
         above[i]   = (i + 1 > 32'(floor_q));
         below[i]   = (i + 1 < 32'(floor_q));
      end
      ahead   = dir_up_q ? |(pending_q & above) : |(pending_q & below);
      behind  = dir_up_q ? |(pending_q & below) : |(pending_q & above);
      step_ok = dir_up_q ? (floor_q < TopFloor) : (floor_q > 3'd1);
      if (floor_q > TopFloor) begin
         clamp_floor = TopFloor;
      end else if (floor_q == 3'd0) begin
         clamp_floor = 3'd1;
      end else begin
         clamp_floor = floor_q;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         floor_q   <= 3'd1;
         dir_up_q  <= 1'b1;
         timer_q   <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         dir_up_q  <= dir_up_d;
         timer_q   <= timer_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin : next_state
      state_d    = state_q;
      floor_d    = floor_q;
      dir_up_d   = dir_up_q;
      timer_d    = timer_q;
      req_masked = call_req_i;
      clear      = '0;
      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (|(pending_q & cur_oh)) begin
               state_d = StDoor;
               clear   = cur_oh;
            end else if (ahead) begin
               state_d = StMove;
            end else if (behind) begin
               dir_up_d = ~dir_up_q;
               state_d  = StMove;
            end
         end
         StMove: begin
            if (timer_q >= TravelLast) begin
               timer_d = '0;
               if (!step_ok) begin
                  // Would leave the shaft: pin the floor and stop.
                  floor_d = clamp_floor;
                  state_d = StIdle;
               end else begin
                  floor_d = next_floor;
                  if (|(pending_q & next_oh)) begin
                     state_d = StDoor;
                     clear   = next_oh;
                  end
               end
            end else begin
               timer_d = timer_q + TimerOne;
            end
         end
         StDoor: begin
            req_masked = call_req_i & ~cur_oh;
            if (hold || |(call_req_i & cur_oh)) begin
               timer_d = '0;
            end else if (timer_q >= DoorLast) begin
               timer_d = '0;
               if (ahead) begin
                  state_d = StMove;
               end else if (behind) begin
                  dir_up_d = ~dir_up_q;
                  state_d  = StMove;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               timer_d = timer_q + TimerOne;
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase
      pending_d = (pending_q | req_masked) & ~clear;
   end

   always_comb begin : outputs
      moving_o = (state_q == StMove);
      door_n_o = (state_q != StDoor);
   end

   assign current_floor_o = floor_q;
   assign dir_up_o        = dir_up_q;
   assign pending_o       = pending_q;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Randomized bench for elevator_car_controller: directed scenarios plus random calls/resets,
// all checked every cycle against an event-level reference model.
module tb_elevator_car_controller;

   localparam int unsigned FLOORS = 6;
   localparam int unsigned TRAVEL = 4;
   localparam int unsigned DOOR   = 3;
   localparam int MIdle = 0;
   localparam int MMove = 1;
   localparam int MDoor = 2;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [FLOORS-1:0] call_req = '0;
   logic              hold = 1'b0;
   logic [2:0]        current_floor;
   logic              door_n, moving, dir_up;
   logic [FLOORS-1:0] pending;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: mode plus a countdown of cycles left in the current activity.
   int                m_floor, m_mode, m_left;
   bit                m_dir;
   bit [FLOORS-1:0]   m_pend;

   int                stops_q[$];
   int                wins_q[$];
   int                low_len = 0;
   logic              prev_door_n = 1'b1;

   elevator_car_controller #(
      .FLOORS       (FLOORS),
      .TRAVEL_CYCLES(TRAVEL),
      .DOOR_CYCLES  (DOOR)
   ) dut (
      .clock_i        (clock),
      .reset_i        (reset),
      .call_req_i     (call_req),
`ifdef ELEVATOR_DOOR_HOLD_EN
      .door_hold_i    (hold),
`endif
      .current_floor_o(current_floor),
      .door_n_o       (door_n),
      .moving_o       (moving),
      .dir_up_o       (dir_up),
      .pending_o      (pending)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_ahead();
      for (int f = 1; f <= int'(FLOORS); f++)
         if (m_pend[f-1] && (m_dir ? (f > m_floor) : (f < m_floor))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_behind();
      for (int f = 1; f <= int'(FLOORS); f++)
         if (m_pend[f-1] && (m_dir ? (f < m_floor) : (f > m_floor))) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_edge(input logic [FLOORS-1:0] req, input logic rst, input logic hld);
      bit [FLOORS-1:0] np;
      bit [FLOORS-1:0] clr;
      int nf;
      if (rst) begin
         m_floor = 1; m_dir = 1'b1; m_pend = '0; m_mode = MIdle; m_left = 0;
         return;
      end
      clr = '0;
      np  = m_pend | req;
      case (m_mode)
         MIdle: begin
            if (m_pend[m_floor-1]) begin
               m_mode = MDoor; m_left = DOOR; clr[m_floor-1] = 1'b1;
            end else if (m_ahead()) begin
               m_mode = MMove; m_left = TRAVEL;
            end else if (m_behind()) begin
               m_dir = !m_dir; m_mode = MMove; m_left = TRAVEL;
            end
         end
         MMove: begin
            m_left--;
            if (m_left == 0) begin
               nf = m_dir ? m_floor + 1 : m_floor - 1;
               if (m_pend[nf-1]) begin
                  m_mode = MDoor; m_left = DOOR; clr[nf-1] = 1'b1;
               end else begin
                  m_left = TRAVEL;
               end
               m_floor = nf;
            end
         end
         default: begin
            np[m_floor-1] = 1'b0;
            if (req[m_floor-1] || hld) begin
               m_left = DOOR;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  if (m_ahead()) begin
                     m_mode = MMove; m_left = TRAVEL;
                  end else if (m_behind()) begin
                     m_dir = !m_dir; m_mode = MMove; m_left = TRAVEL;
                  end else begin
                     m_mode = MIdle;
                  end
               end
            end
         end
      endcase
      m_pend = np & ~clr;
   endtask

   task automatic do_cycle(input logic [FLOORS-1:0] req, input logic rst);
      call_req = req;
      reset    = rst;
      @(posedge clock);
      model_edge(req, rst, hold);
      #1;
      check_val("floor",   32'(current_floor), 32'(m_floor));
      check_val("door_n",  32'(door_n),  (m_mode == MDoor) ? 32'd0 : 32'd1);
      check_val("moving",  32'(moving),  (m_mode == MMove) ? 32'd1 : 32'd0);
      check_val("dir_up",  32'(dir_up),  32'(m_dir));
      check_val("pending", 32'(pending), 32'(m_pend));
      if (prev_door_n && !door_n) stops_q.push_back(int'(current_floor));
      if (!door_n) low_len++;
      if (!prev_door_n && door_n) begin
         wins_q.push_back(low_len);
         low_len = 0;
      end
      prev_door_n = door_n;
   endtask

   task automatic clear_log();
      stops_q.delete();
      wins_q.delete();
      low_len = 0;
   endtask

   initial begin
      int exp_stops[3];
      bit dir_dropped;
      logic [FLOORS-1:0] r;

      // Reset state
      do_cycle('0, 1'b1);
      check_val("rst_floor", 32'(current_floor), 32'd1);
      check_val("rst_door",  32'(door_n), 32'd1);
      check_val("rst_move",  32'(moving), 32'd0);
      check_val("rst_dir",   32'(dir_up), 32'd1);
      check_val("rst_pend",  32'(pending), 32'd0);

      // Single call to floor 3, exact cycle timing
      for (int c = 1; c <= 13; c++) begin
         do_cycle((c == 1) ? 6'b000100 : 6'b000000, 1'b0);
         if (c == 2) check_val("t1_moving_c2", 32'(moving), 32'd1);
         if (c == 6) check_val("t1_floor_c6", 32'(current_floor), 32'd2);
         if (c >= 10 && c <= 12) begin
            check_val("t1_floor_door", 32'(current_floor), 32'd3);
            check_val("t1_door_low", 32'(door_n), 32'd0);
         end
         if (c == 13) begin
            check_val("t1_door_end", 32'(door_n), 32'd1);
            check_val("t1_idle", 32'(moving), 32'd0);
            check_val("t1_pend_end", 32'(pending), 32'd0);
         end
      end

      // Calls 2,5,3 together from floor 1: stops 2,3,5 with 3-cycle windows, always up
      do_cycle('0, 1'b1);
      clear_log();
      dir_dropped = 1'b0;
      do_cycle(6'b010110, 1'b0);
      for (int c = 0; c < 45; c++) begin
         do_cycle('0, 1'b0);
         if (!dir_up) dir_dropped = 1'b1;
      end
      exp_stops = '{2, 3, 5};
      check_val("t2_nstops", 32'(stops_q.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check_val("t2_stop", (i < stops_q.size()) ? 32'(stops_q[i]) : 32'd0,
                   32'(exp_stops[i]));
         check_val("t2_window", (i < wins_q.size()) ? 32'(wins_q[i]) : 32'd0, 32'(DOOR));
      end
      check_val("t2_dir_up", 32'(dir_dropped), 32'd0);

      // Heading up past 3 toward 5, then call for 1: serve 5 first, then reverse
      do_cycle('0, 1'b1);
      clear_log();
      do_cycle(6'b010000, 1'b0);
      for (int n = 0; n < 40 && !(current_floor == 3'd3 && moving); n++) do_cycle('0, 1'b0);
      check_val("t3_reach3", 32'(current_floor == 3'd3 && moving), 32'd1);
      do_cycle(6'b000001, 1'b0);
      for (int c = 0; c < 50; c++) do_cycle('0, 1'b0);
      check_val("t3_nstops", 32'(stops_q.size()), 32'd2);
      check_val("t3_first", (stops_q.size() > 0) ? 32'(stops_q[0]) : 32'd0, 32'd5);
      check_val("t3_second", (stops_q.size() > 1) ? 32'(stops_q[1]) : 32'd0, 32'd1);
      check_val("t3_dir", 32'(dir_up), 32'd0);
      check_val("t3_floor", 32'(current_floor), 32'd1);

      // Idle at floor 4, call for 4: door opens in place, repeat call extends dwell
      do_cycle('0, 1'b1);
      do_cycle(6'b001000, 1'b0);
      for (int c = 0; c < 40; c++) do_cycle('0, 1'b0);
      check_val("t4_at4", 32'(current_floor), 32'd4);
      check_val("t4_idle", 32'(door_n && !moving), 32'd1);
      clear_log();
      do_cycle(6'b001000, 1'b0);
      do_cycle('0, 1'b0);
      check_val("t4_door_2cyc", 32'(door_n), 32'd0);
      do_cycle(6'b001000, 1'b0);
      for (int c = 0; c < 10; c++) begin
         do_cycle('0, 1'b0);
         check_val("t4_no_move", 32'(moving), 32'd0);
      end
      check_val("t4_window", (wins_q.size() > 0) ? 32'(wins_q[0]) : 32'd0, 32'(1 + DOOR));

      // Reset mid-travel between floors 2 and 3
      do_cycle('0, 1'b1);
      do_cycle(6'b010000, 1'b0);
      for (int n = 0; n < 40 && !(current_floor == 3'd2 && moving); n++) do_cycle('0, 1'b0);
      check_val("t5_reach2", 32'(current_floor == 3'd2 && moving), 32'd1);
      do_cycle('0, 1'b0);
      do_cycle('0, 1'b1);
      check_val("t5_floor", 32'(current_floor), 32'd1);
      check_val("t5_door", 32'(door_n), 32'd0 + 32'd1);
      check_val("t5_move", 32'(moving), 32'd0);
      check_val("t5_pend", 32'(pending), 32'd0);

`ifdef ELEVATOR_DOOR_HOLD_EN
      // Door hold for 10 cycles during dwell stretches the window to 10 + DOOR
      do_cycle('0, 1'b1);
      clear_log();
      do_cycle(6'b000010, 1'b0);
      for (int n = 0; n < 30 && door_n; n++) do_cycle('0, 1'b0);
      check_val("t6_open", 32'(door_n), 32'd0);
      hold = 1'b1;
      for (int c = 0; c < 10; c++) do_cycle('0, 1'b0);
      hold = 1'b0;
      for (int c = 0; c < 10; c++) do_cycle('0, 1'b0);
      check_val("t6_window", (wins_q.size() > 0) ? 32'(wins_q[0]) : 32'd0, 32'(10 + DOOR));
`endif

      // Random calls, occasional resets (and door holds when present)
      do_cycle('0, 1'b1);
      for (int c = 0; c < 3000; c++) begin
         r = ($urandom_range(0, 5) == 0) ? FLOORS'($urandom) : '0;
`ifdef ELEVATOR_DOOR_HOLD_EN
         hold = ($urandom_range(0, 9) == 0);
`endif
         do_cycle(r, $urandom_range(0, 399) == 0);
      end
      hold = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
